// File: rtl/fir_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : fir_sample_feeder
// Description : Upstream transmitter for the FIR filter blocks. Host-written
//               samples are buffered in a small FIFO and offered to the filter
//               on a valid/ready handshake at a programmable sample rate.
// Ports       : i_clk, i_rst (sync, active-high), i_en (global hold)
//               iv_wr_data / i_wr_en      host enqueue, o_full / o_empty status
//               iv_rate_div               sample period minus 1 (0 = unpaced)
//               ov_din / o_din_valid      sample offered, held until i_ready
//               o_underrun / o_overflow   sticky errors, cleared by i_clr_err
//               ov_sent_count             handoffs since reset (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sample_feeder #(
    parameter int DATA_WIDTH     = 24,
    parameter int FIFO_DEPTH     = 16,
    parameter int RATE_DIV_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic [DATA_WIDTH-1:0]     iv_wr_data,
    input  logic                      i_wr_en,
    output logic                      o_full,
    output logic                      o_empty,
    input  logic [RATE_DIV_WIDTH-1:0] iv_rate_div,
    output logic [DATA_WIDTH-1:0]     ov_din,
    output logic                      o_din_valid,
    input  logic                      i_ready,
    output logic                      o_underrun,
    output logic                      o_overflow,
    input  logic                      i_clr_err,
    output logic [31:0]               ov_sent_count
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]        r_wr_ptr;
    logic [c_ptr_w-1:0]        r_rd_ptr;
    logic [c_cnt_w-1:0]        r_count;
    logic [c_cnt_w-1:0]        w_count_nxt;
    logic                      r_full;
    logic                      r_empty;
    logic                      w_push;
    logic                      w_pop;

    logic [RATE_DIV_WIDTH-1:0] r_div_cnt;
    logic                      w_paced;
    logic                      w_tick;
    logic                      r_pending;
    logic                      w_pending_eff;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_handoff;

    logic [DATA_WIDTH-1:0]     r_din;
    logic                      r_din_valid;
    logic                      r_underrun;
    logic                      r_overflow;
    logic                      w_set_underrun;
    logic                      w_set_overflow;
    logic [31:0]               r_sent_count;

    // ------------------------------------------------------------------
    // Sample FIFO: count-based registered full/empty so every entry is usable
    // ------------------------------------------------------------------
    assign w_push         = i_en & i_wr_en & ~r_full;
    // A write into a full FIFO is lost even if a pop frees a slot this cycle.
    assign w_set_overflow = i_en & i_wr_en & r_full;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_cnt_w'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= iv_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Rate divider: ticks once every iv_rate_div+1 enabled cycles
    // ------------------------------------------------------------------
    assign w_paced       = |iv_rate_div;
    assign w_tick        = i_en & (r_div_cnt == '0);
    // With pacing off, a slot is always available.
    assign w_pending_eff = r_pending | ~w_paced;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_cnt <= iv_rate_div;
            r_pending <= 1'b0;
        end else if (i_en) begin
            if (w_tick) begin
                r_div_cnt <= iv_rate_div;
            end else begin
                r_div_cnt <= r_div_cnt - RATE_DIV_WIDTH'(1);
            end
            // A fresh slot wins over consumption of the previous one.
            if (w_tick) begin
                r_pending <= 1'b1;
            end else if (w_pop) begin
                r_pending <= 1'b0;
            end
        end
    end

    // A slot is missed if the previous one is still unused, or if the
    // feeder is idle with nothing to send when the slot arrives.
    assign w_set_underrun = w_paced & w_tick &
                            ((r_pending & ~w_pop) | ((r_state == IDLE) & r_empty));

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_handoff   = 1'b0;
        if (i_en) begin
            case (r_state)
                IDLE: begin
                    if (w_pending_eff && !r_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = OFFER;
                    end
                end
                OFFER: begin
                    if (i_ready) begin
                        w_handoff   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Offer datapath, counters and sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_din        <= '0;
            r_din_valid  <= 1'b0;
            r_sent_count <= '0;
        end else begin
            // ov_din only changes on a pop, so it stays put through the
            // handoff edge and the filter captures the held value.
            if (w_pop) begin
                r_din       <= r_mem[r_rd_ptr];
                r_din_valid <= 1'b1;
            end else if (w_handoff) begin
                r_din_valid <= 1'b0;
            end
            if (w_handoff) begin
                r_sent_count <= r_sent_count + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_set_underrun) begin
                r_underrun <= 1'b1;
            end else if (i_clr_err) begin
                r_underrun <= 1'b0;
            end
            if (w_set_overflow) begin
                r_overflow <= 1'b1;
            end else if (i_clr_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign ov_din        = r_din;
    assign o_din_valid   = r_din_valid;
    assign o_underrun    = r_underrun;
    assign o_overflow    = r_overflow;
    assign ov_sent_count = r_sent_count;

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_sample_feeder
// Description : Self-checking bench for fir_sample_feeder. A queue-based
//               reference model tracks the FIFO, pacing slots, offer and
//               sticky flags; every cycle the DUT outputs are compared with
//               it, and directed scenarios add explicit expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_sample_feeder;

    localparam int DW    = 24;
    localparam int DEPTH = 16;
    localparam int RW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic [RW-1:0] rate_div = '0;
    logic          rdy = 1'b0;
    logic          clr_err = 1'b0;
    logic          full, empty, din_valid, underrun, overflow;
    logic [DW-1:0] din;
    logic [31:0]   sent;

    always #5 clk = ~clk;

    fir_sample_feeder #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (DEPTH),
        .RATE_DIV_WIDTH (RW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .iv_wr_data    (wr_data),
        .i_wr_en       (wr_en),
        .o_full        (full),
        .o_empty       (empty),
        .iv_rate_div   (rate_div),
        .ov_din        (din),
        .o_din_valid   (din_valid),
        .i_ready       (rdy),
        .o_underrun    (underrun),
        .o_overflow    (overflow),
        .i_clr_err     (clr_err),
        .ov_sent_count (sent)
    );

    // Reference model state
    logic [DW-1:0] m_q[$];
    int            m_div;
    bit            m_pend, m_valid, m_under, m_over;
    logic [DW-1:0] m_din;
    logic [31:0]   m_sent;

    // Filter model / bookkeeping
    int            lat;
    bit            spur;
    int            age;
    int            cyc_no;
    bit            prev_valid;
    logic [DW-1:0] got_q[$];
    int            rise_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit            paced, tick, is_empty, is_full, pend_eff, pop, handoff, set_u, set_o;
        logic [DW-1:0] head;
        if (rst) begin
            m_q.delete();
            m_div   = int'(rate_div);
            m_pend  = 1'b0;
            m_valid = 1'b0;
            m_din   = '0;
            m_sent  = '0;
            m_under = 1'b0;
            m_over  = 1'b0;
            return;
        end
        if (!en) begin
            if (clr_err) begin
                m_under = 1'b0;
                m_over  = 1'b0;
            end
            return;
        end
        paced    = (rate_div != '0);
        tick     = (m_div == 0);
        is_empty = (m_q.size() == 0);
        is_full  = (m_q.size() == DEPTH);
        pend_eff = m_pend || !paced;
        pop      = !m_valid && pend_eff && !is_empty;
        handoff  = m_valid && rdy;
        set_u    = paced && tick && ((m_pend && !pop) || (!m_valid && is_empty));
        set_o    = wr_en && is_full;
        m_div    = tick ? int'(rate_div) : m_div - 1;
        if (tick)     m_pend = 1'b1;
        else if (pop) m_pend = 1'b0;
        if (pop) begin
            head    = m_q.pop_front();
            m_din   = head;
            m_valid = 1'b1;
        end else if (handoff) begin
            m_valid = 1'b0;
            m_sent  = m_sent + 32'd1;
        end
        if (wr_en && !is_full) m_q.push_back(wr_data);
        if (set_u)        m_under = 1'b1;
        else if (clr_err) m_under = 1'b0;
        if (set_o)        m_over = 1'b1;
        else if (clr_err) m_over = 1'b0;
    endtask

    // One clock: filter model drives ready, model steps, DUT is compared.
    task automatic cycle();
        bit was_v;
        rdy = m_valid ? (age >= lat) : spur;
        if (din_valid && rdy && en && !rst) got_q.push_back(din);
        was_v = m_valid;
        model_step();
        @(posedge clk);
        #1;
        cyc_no++;
        chk_eq("valid",    32'(din_valid), 32'(m_valid));
        chk_eq("din",      32'(din),       32'(m_din));
        chk_eq("full",     32'(full),      32'(m_q.size() == DEPTH));
        chk_eq("empty",    32'(empty),     32'(m_q.size() == 0));
        chk_eq("underrun", 32'(underrun),  32'(m_under));
        chk_eq("overflow", 32'(overflow),  32'(m_over));
        chk_eq("sent",     sent,           m_sent);
        if (din_valid && !prev_valid) rise_q.push_back(cyc_no);
        prev_valid = din_valid;
        age = (m_valid && was_v) ? age + 1 : 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; clr_err = 1'b0; spur = 1'b0; en = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        got_q.delete();
        rise_q.delete();
    endtask

    task automatic push(input logic [DW-1:0] v);
        wr_data = v; wr_en = 1'b1;
        cycle();
        wr_en = 1'b0;
    endtask

    logic [DW-1:0] vals[17];
    logic [DW-1:0] d0;
    int            n_stab, n_stale;

    initial begin
        cyc_no = 0; age = 0; lat = 0; spur = 0; prev_valid = 0;
        m_q.delete(); m_div = 0; m_pend = 0; m_valid = 0; m_din = '0;
        m_sent = '0; m_under = 0; m_over = 0;

        // 1: unpaced, three boundary values, ready 3 cycles after valid
        rate_div = '0; lat = 3;
        do_reset();
        chk_eq("rst_valid", 32'(din_valid), 32'd0);
        chk_eq("rst_empty", 32'(empty), 32'd1);
        chk_eq("rst_sent",  sent, 32'd0);
        push(24'h000001); push(24'h7FFFFF); push(24'h800000);
        repeat (25) cycle();
        chk_eq("s1_sent",  sent, 32'd3);
        chk_eq("s1_empty", 32'(empty), 32'd1);
        chk_eq("s1_flags", {30'd0, underrun, overflow}, 32'd0);
        chk_eq("s1_nout",  32'(got_q.size()), 32'd3);
        vals[0] = 24'h000001; vals[1] = 24'h7FFFFF; vals[2] = 24'h800000;
        for (int i = 0; i < 3; i++)
            chk_eq("s1_order", (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(vals[i]));

        // 2: period 10, five preloaded samples
        rate_div = RW'(9); lat = 2;
        do_reset();
        for (int i = 0; i < 5; i++) push(DW'($urandom));
        for (int k = 0; k < 80 && rise_q.size() < 5; k++) cycle();
        repeat (3) cycle();
        chk_eq("s2_under", 32'(underrun), 32'd0);
        chk_eq("s2_rises", 32'(rise_q.size()), 32'd5);
        for (int i = 1; i < 5; i++)
            chk_eq("s2_gap", (i < rise_q.size()) ? 32'(rise_q[i] - rise_q[i-1]) : 32'd0, 32'd10);

        // 3: one sample then starvation; clear and re-arm underrun
        rate_div = RW'(4); lat = 1;
        do_reset();
        push(DW'($urandom));
        for (int k = 0; k < 30 && sent != 32'd1; k++) cycle();
        chk_eq("s3_sent", sent, 32'd1);
        for (int k = 0; k < 20 && underrun !== 1'b1; k++) cycle();
        chk_eq("s3_under_set", 32'(underrun), 32'd1);
        clr_err = 1'b1; cycle(); clr_err = 1'b0;
        chk_eq("s3_under_clr", 32'(underrun), 32'd0);
        cycle();
        chk_eq("s3_under_held", 32'(underrun), 32'd0);
        chk_eq("s3_empty", 32'(empty), 32'd1);
        for (int k = 0; k < 10 && underrun !== 1'b1; k++) cycle();
        chk_eq("s3_under_reset", 32'(underrun), 32'd1);

        // 4: overfill by one, then drain unpaced
        rate_div = RW'(1000); lat = 1;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            vals[i] = DW'($urandom);
            push(vals[i]);
            if (i == 15) begin
                chk_eq("s4_full16", 32'(full), 32'd1);
                chk_eq("s4_noovf16", 32'(overflow), 32'd0);
            end
        end
        chk_eq("s4_ovf", 32'(overflow), 32'd1);
        rate_div = '0;
        for (int k = 0; k < 200 && sent != 32'd16; k++) cycle();
        repeat (3) cycle();
        chk_eq("s4_nout", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            chk_eq("s4_order", (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(vals[i]));
        chk_eq("s4_empty", 32'(empty), 32'd1);

        // 5: ready withheld 30 cycles
        rate_div = RW'(4); lat = 30;
        do_reset();
        push(DW'($urandom));
        for (int k = 0; k < 20 && din_valid !== 1'b1; k++) cycle();
        d0 = din; n_stab = 0;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            if (din_valid !== 1'b1 || din !== d0) n_stab++;
            if (k == 6) chk_eq("s5_under_first", 32'(underrun), 32'd0);
        end
        chk_eq("s5_stable", 32'(n_stab), 32'd0);
        chk_eq("s5_under_second", 32'(underrun), 32'd1);
        cycle();
        chk_eq("s5_sent", sent, 32'd1);
        chk_eq("s5_valid_low", 32'(din_valid), 32'd0);
        chk_eq("s5_value", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'(d0));

        // 6: reset mid-offer with three samples still queued
        rate_div = RW'(2); lat = 5;
        do_reset();
        for (int i = 0; i < 5; i++) push(DW'($urandom));
        for (int k = 0; k < 40 && sent != 32'd1; k++) cycle();
        for (int k = 0; k < 20 && din_valid !== 1'b1; k++) cycle();
        chk_eq("s6_offering", 32'(din_valid), 32'd1);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk_eq("s6_valid", 32'(din_valid), 32'd0);
        chk_eq("s6_empty", 32'(empty), 32'd1);
        chk_eq("s6_sent",  sent, 32'd0);
        chk_eq("s6_flags", {30'd0, underrun, overflow}, 32'd0);
        n_stale = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (din_valid !== 1'b0) n_stale++;
        end
        chk_eq("s6_no_stale", 32'(n_stale), 32'd0);

        // 7: randomized traffic against the model
        rate_div = RW'($urandom_range(0, 6)); lat = 1;
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            if (k % 100 == 0) begin
                rate_div = RW'($urandom_range(0, 6));
                lat      = $urandom_range(0, 4);
            end
            en      = ($urandom_range(0, 9) != 0);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_data = DW'($urandom);
            clr_err = ($urandom_range(0, 15) == 0);
            spur    = $urandom_range(0, 1);
            rst     = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0; en = 1'b1; wr_en = 1'b0; clr_err = 1'b0; spur = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
- Upstream transmitter for the FIR filter blocks. It buffers host-written samples in a small FIFO and paces them out at a programmable sample rate.
- Each sample is offered on the filter's input handshake (valid held until a ready pulse).
- Sits between the sample source (host/DMA/test logic) and the filter's iv_din / i_din_valid / o_ready ports.

Parameters:
- DATA_WIDTH, 24, sample width in bits (signed two's complement, passed through unchanged).
- FIFO_DEPTH, 16, sample buffer entries; power of 2, ≥2.
- RATE_DIV_WIDTH, 16, width of the sample-period divider input.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_en  in  1  enable; when low, FIFO, divider, FSM and counters all hold (host writes ignored).
- iv_wr_data  in  DATA_WIDTH  host sample to enqueue.
- i_wr_en  in  1  enqueue strobe.
- o_full  out  1  FIFO full.
- o_empty  out  1  FIFO empty.
- iv_rate_div  in  RATE_DIV_WIDTH  sample period minus 1, in cycles; 0 = unpaced.
- ov_din  out  DATA_WIDTH  sample offered to the filter.
- o_din_valid  out  1  sample offered.
- i_ready  in  1  filter consumed the sample (one-cycle pulse).
- o_underrun  out  1  sticky: a sample slot was missed.
- o_overflow  out  1  sticky: a host write was dropped.
- i_clr_err  in  1  clears o_underrun and o_overflow.
- ov_sent_count  out  32  samples handed off since reset, wrapping.

Behaviour:
- Reset values: o_din_valid=0, ov_din=0, o_full=0, o_empty=1, o_underrun=0, o_overflow=0, ov_sent_count=0; FIFO emptied; divider loaded with iv_rate_div; FSM in IDLE; pending=0.
- FIFO:
  - Push when i_wr_en & i_en & !o_full.
  - Push while full is dropped and sets o_overflow, even if a pop occurs in the same cycle.
  - Full/empty are registered and count-based, so FIFO_DEPTH entries are usable.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle (not full) leaves the count unchanged.
- Rate divider:
  - Down-counter runs whenever i_en=1.
  - At 0 it emits a one-cycle tick and reloads iv_rate_div (sampled at reload).
  - A tick sets pending.
  - A tick while pending is already 1 sets o_underrun (missed slot).
  - A tick while the FSM is in IDLE and the FIFO is empty sets o_underrun; pending is still set.
- iv_rate_div=0: pacing disabled, pending treated as constantly 1, underrun detection disabled.
- FSM states IDLE and OFFER:
  - IDLE: if pending & !o_empty: ov_din <= FIFO head, pop, o_din_valid <= 1, pending <= 0, go to OFFER. Valid rises on the clock edge after the condition holds (1-cycle latency).
  - OFFER: ov_din and o_din_valid held stable. When i_ready=1 is sampled: o_din_valid <= 0, ov_sent_count += 1, return to IDLE. The earliest next offer is one cycle later, so valid is low for at least one cycle between samples.
  - i_ready in IDLE is ignored.
- ov_din stays stable through the edge where i_ready is sampled, so the filter captures the held value.
- A tick arriving in OFFER sets pending (or underrun, if pending was already 1); it does not disturb the current offer.
- i_clr_err and a set event in the same cycle: the set wins.
- i_rst in OFFER: valid drops at that edge and the in-flight and buffered samples are discarded.
- i_rst takes priority over i_en.

Test Plan:
- Reset, iv_rate_div=0, push 24'h000001, 24'h7FFFFF, 24'h800000, filter model pulses i_ready 3 cycles after each valid → ov_din sequence 000001, 7FFFFF, 800000 in order; valid low ≥1 cycle between samples; ov_sent_count=3; o_empty=1; no error flags.
- iv_rate_div=9, FIFO preloaded with 5 samples, i_ready returned 2 cycles after valid → o_din_valid rising edges exactly 10 cycles apart; o_underrun stays 0.
- iv_rate_div=4, one sample pushed, then nothing → first sample sent; next tick with FIFO empty sets o_underrun=1; i_clr_err clears it to 0 while the FIFO stays empty, until the next tick sets it again.
- Push 17 samples with FIFO_DEPTH=16 and no pops → o_full=1 after the 16th push; 17th dropped; o_overflow=1; drain yields exactly the first 16 values in order.
- i_ready withheld 30 cycles with iv_rate_div=4 → ov_din/o_din_valid stable all 30 cycles; o_underrun=1 on the second missed tick; the sample is handed off on the i_ready pulse.
- i_rst asserted mid-OFFER with 3 samples queued → next cycle o_din_valid=0, o_empty=1, ov_sent_count=0, flags 0; no stale sample offered afterwards.
